// File: rtl/seq_alu_if.sv
// Start/busy/done request and double-width result bundle between the control unit and seq_alu.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       opcode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;

  modport master (
    output start, opcode, A, B,
    input  busy, done, result_lo, result_hi, div_by_zero
  );

  modport slave (
    input  start, opcode, A, B,
    output busy, done, result_lo, result_hi, div_by_zero
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle signed ALU: one-cycle logic/arith/shift ops, WIDTH-iteration Booth MUL and restoring DIV.
// SEQ_ALU_FAST_MUL_EN swaps the Booth loop for a one-cycle combinational multiplier.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic      clock,
  input logic      clear,
  seq_alu_if.slave bus
);
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic             dbz_q, dbz_d;

  logic [SHW-1:0]     amt;
  logic [2*WIDTH-1:0] rot;
  logic [WIDTH-1:0]   quick_lo, quick_hi, a_mag_in;

`ifdef SEQ_ALU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  // Sign-extended unsigned product has the same low 2*WIDTH bits as the signed one.
  assign fast_prod = {{WIDTH{bus.A[WIDTH-1]}}, bus.A} * {{WIDTH{bus.B[WIDTH-1]}}, bus.B};
`endif

  always_comb begin
    amt      = bus.B[SHW-1:0];
    rot      = '0;
    quick_lo = '0;
    quick_hi = '0;
    a_mag_in = bus.A[WIDTH-1] ? ('0 - bus.A) : bus.A;
    case (bus.opcode)
      OP_OR:   quick_lo = bus.A | bus.B;
      OP_AND:  quick_lo = bus.A & bus.B;
      OP_NOT:  quick_lo = ~bus.A;
      OP_ADD:  quick_lo = bus.A + bus.B;
      OP_SUB:  quick_lo = bus.A - bus.B;
      OP_NEG:  quick_lo = '0 - bus.A;
      OP_SHR:  quick_lo = bus.A >> amt;
      OP_SHRA: quick_lo = $unsigned($signed(bus.A) >>> amt);
      OP_SHL:  quick_lo = bus.A << amt;
      OP_ROR: begin
        rot      = {bus.A, bus.A} >> amt;
        quick_lo = rot[WIDTH-1:0];
      end
      OP_ROL: begin
        rot      = {bus.A, bus.A} << amt;
        quick_lo = rot[2*WIDTH-1:WIDTH];
      end
`ifdef SEQ_ALU_FAST_MUL_EN
      OP_MUL: begin
        quick_lo = fast_prod[WIDTH-1:0];
        quick_hi = fast_prod[2*WIDTH-1:WIDTH];
      end
`endif
      default: ;
    endcase
  end

`ifndef SEQ_ALU_FAST_MUL_EN
  logic [WIDTH:0]     booth_sum;
  logic [2*WIDTH+1:0] booth_sh;

  // One Booth step on {hi, lo, q-1}; hi carries an extra sign bit so MIN*MIN cannot overflow.
  always_comb begin
    booth_sum = acc_hi_q;
    case ({acc_lo_q[0], qm1_q})
      2'b01:   booth_sum = acc_hi_q + {a_q[WIDTH-1], a_q};
      2'b10:   booth_sum = acc_hi_q - {a_q[WIDTH-1], a_q};
      default: ;
    endcase
    booth_sh = {booth_sum[WIDTH], booth_sum, acc_lo_q};
  end
`endif

  logic [WIDTH-1:0] b_mag, div_lo_n, quo_fix, rem_fix;
  logic [WIDTH:0]   rem_sh, trial, div_hi_n;

  // Restoring step on magnitudes; signs are reapplied on the final iteration.
  always_comb begin
    b_mag  = b_q[WIDTH-1] ? ('0 - b_q) : b_q;
    rem_sh = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, b_mag};
    if (trial[WIDTH]) begin
      div_hi_n = rem_sh;
      div_lo_n = {acc_lo_q[WIDTH-2:0], 1'b0};
    end else begin
      div_hi_n = trial;
      div_lo_n = {acc_lo_q[WIDTH-2:0], 1'b1};
    end
    quo_fix = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? ('0 - div_lo_n) : div_lo_n;
    rem_fix = a_q[WIDTH-1] ? ('0 - div_hi_n[WIDTH-1:0]) : div_hi_n[WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    qm1_d    = qm1_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dbz_d    = 1'b0;
          a_d      = bus.A;
          b_d      = bus.B;
          cnt_d    = '0;
          qm1_d    = 1'b0;
          acc_hi_d = '0;
          if (bus.opcode == OP_DIV && bus.B != '0) begin
            acc_lo_d = a_mag_in;
            state_d  = S_DIV;
          end else if (bus.opcode == OP_DIV) begin
            res_lo_d = '0;
            res_hi_d = bus.A;
            dbz_d    = 1'b1;
            state_d  = S_DONE;
          end
`ifndef SEQ_ALU_FAST_MUL_EN
          else if (bus.opcode == OP_MUL) begin
            acc_lo_d = bus.B;
            state_d  = S_MUL;
          end
`endif
          else begin
            res_lo_d = quick_lo;
            res_hi_d = quick_hi;
            state_d  = S_DONE;
          end
        end
      end
`ifndef SEQ_ALU_FAST_MUL_EN
      S_MUL: begin
        acc_hi_d = booth_sh[2*WIDTH+1:WIDTH+1];
        acc_lo_d = booth_sh[WIDTH:1];
        qm1_d    = booth_sh[0];
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          res_lo_d = booth_sh[WIDTH:1];
          res_hi_d = booth_sh[2*WIDTH:WIDTH+1];
          state_d  = S_DONE;
        end
      end
`endif
      S_DIV: begin
        acc_hi_d = div_hi_n;
        acc_lo_d = div_lo_n;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          res_lo_d = quo_fix;
          res_hi_d = rem_fix;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      qm1_q    <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      qm1_q    <= qm1_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.result_lo   = res_lo_q;
  assign bus.result_hi   = res_hi_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed vector bench for seq_alu at WIDTH=32: opcode table plus abort/ignore/hold sequences.
module tb_seq_alu;
  localparam int W = 32;
`ifdef SEQ_ALU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;
  localparam int TIMEOUT = 200;
  localparam int NV      = 24;

  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dbz;
    int           lat;
  } vec_t;

  logic clk = 1'b0;
  logic clr;
  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t vecs[NV];

  seq_alu_if #(.WIDTH(W)) bus ();
  seq_alu #(.WIDTH(W)) dut (.clock(clk), .clear(clr), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Returns the number of cycles from the start edge until done is seen (TIMEOUT if never).
  task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.opcode = op;
    bus.A      = a;
    bus.B      = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int done_seen;

    vecs[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0,        1'b0, 1};
    vecs[1]  = '{OP_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'h0,        1'b0, 1};
    vecs[2]  = '{OP_OR,   32'hF0F00000, 32'h0000FFFF, 32'hF0F0FFFF, 32'h0,        1'b0, 1};
    vecs[3]  = '{OP_AND,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 32'h0,        1'b0, 1};
    vecs[4]  = '{OP_NOT,  32'h12345678, 32'hFFFFFFFF, 32'hEDCBA987, 32'h0,        1'b0, 1};
    vecs[5]  = '{OP_NEG,  32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'h0,        1'b0, 1};
    vecs[6]  = '{OP_NEG,  32'h80000000, 32'h00000000, 32'h80000000, 32'h0,        1'b0, 1};
    vecs[7]  = '{OP_SHR,  32'h80000000, 32'h00000004, 32'h08000000, 32'h0,        1'b0, 1};
    vecs[8]  = '{OP_SHRA, 32'h80000000, 32'h00000024, 32'hF8000000, 32'h0,        1'b0, 1};
    vecs[9]  = '{OP_SHL,  32'h12345678, 32'h00000020, 32'h12345678, 32'h0,        1'b0, 1};
    vecs[10] = '{OP_SHL,  32'h00000001, 32'h0000001F, 32'h80000000, 32'h0,        1'b0, 1};
    vecs[11] = '{OP_ROR,  32'h00000001, 32'h00000001, 32'h80000000, 32'h0,        1'b0, 1};
    vecs[12] = '{OP_ROL,  32'h80000001, 32'h00000004, 32'h00000018, 32'h0,        1'b0, 1};
    vecs[13] = '{5'b11111, 32'hDEADBEEF, 32'h12345678, 32'h0,       32'h0,        1'b0, 1};
    vecs[14] = '{OP_MUL,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, MUL_LAT};
    vecs[15] = '{OP_MUL,  32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0, MUL_LAT};
    vecs[16] = '{OP_MUL,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 32'h3FFFFFFF, 1'b0, MUL_LAT};
    vecs[17] = '{OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, MUL_LAT};
    vecs[18] = '{OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, DIV_LAT};
    vecs[19] = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, DIV_LAT};
    vecs[20] = '{OP_DIV,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, DIV_LAT};
    vecs[21] = '{OP_DIV,  32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 1'b0, DIV_LAT};
    vecs[22] = '{OP_DIV,  32'h00000005, 32'h00000000, 32'h00000000, 32'h00000005, 1'b1, 1};
    vecs[23] = '{OP_ADD,  32'h00000001, 32'h00000002, 32'h00000003, 32'h0,        1'b0, 1};

    clr        = 1'b1;
    bus.start  = 1'b0;
    bus.opcode = '0;
    bus.A      = '0;
    bus.B      = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset lo",   64'(bus.result_lo), 64'd0);
    chk("reset hi",   64'(bus.result_hi), 64'd0);
    chk("reset dbz",  64'(bus.div_by_zero), 64'd0);
    clr = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d busy@done", i), 64'(bus.busy), 64'd1);
      chk($sformatf("v%0d lo", i), 64'(bus.result_lo), 64'(vecs[i].lo));
      chk($sformatf("v%0d hi", i), 64'(bus.result_hi), 64'(vecs[i].hi));
      chk($sformatf("v%0d dbz", i), 64'(bus.div_by_zero), 64'(vecs[i].dbz));
    end

    // Results hold in IDLE after the done pulse.
    repeat (3) @(negedge clk);
    chk("hold done", 64'(bus.done), 64'd0);
    chk("hold busy", 64'(bus.busy), 64'd0);
    chk("hold lo",   64'(bus.result_lo), 64'h3);

    // A start presented during the DONE cycle is dropped.
    run_op(OP_ADD, 32'd1, 32'd1, lat);
    chk("pre-ignore done", 64'(bus.done), 64'd1);
    bus.start  = 1'b1;
    bus.opcode = OP_SUB;
    bus.A      = 32'd9;
    bus.B      = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    chk("done-start busy", 64'(bus.busy), 64'd0);
    chk("done-start done", 64'(bus.done), 64'd0);
    chk("done-start lo",   64'(bus.result_lo), 64'd2);

    // Abort a DIV with clear after an ignored mid-flight start.
    run_op(OP_MUL, 32'hFFFFFFFD, 32'd7, lat);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.opcode = OP_DIV;
    bus.A      = 32'd100;
    bus.B      = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start  = 1'b1;
    bus.opcode = OP_ADD;
    bus.A      = 32'd4;
    bus.B      = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    chk("abort mid busy", 64'(bus.busy), 64'd1);
    chk("abort mid done", 64'(bus.done), 64'd0);
    chk("abort mid lo",   64'(bus.result_lo), 64'hFFFFFFEB);
    repeat (4) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort done", 64'(bus.done), 64'd0);
    chk("abort lo",   64'(bus.result_lo), 64'd0);
    chk("abort hi",   64'(bus.result_hi), 64'd0);
    chk("abort dbz",  64'(bus.div_by_zero), 64'd0);
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    chk("abort no done", 64'(done_seen), 64'd0);

    run_op(OP_ADD, 32'd2, 32'd3, lat);
    chk("post-abort latency", 64'(lat), 64'd1);
    chk("post-abort lo", 64'(bus.result_lo), 64'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
